// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
//
// Execute-stage branch resolver for the 16-bit pipelined processor.
// It resolves BEQ/BNE conditional branches and jump-register instructions.
// It compares the resolved outcome against the fetch-stage prediction.
// It produces the correct next-fetch address and a flush request.
// Two saturating counters record resolved conditional branches and mispredictions.
//
// Ports
//   clk              in   system clock; the counters update on the rising edge
//   rst_n            in   synchronous active-low reset; clears the counters only
//   BranchTaken      in   fetch-stage prediction (1 = predicted taken)
//   Branch           in   instruction is a conditional branch
//   BEQ_BNE          in   0 = BEQ (take on Zero), 1 = BNE (take on !Zero)
//   Zero             in   ALU zero flag from the comparison
//   JumpReg          in   instruction is a jump-register
//   PC               in   fall-through address (PC of the following instruction)
//   Imm              in   sign-extended two's-complement branch offset
//   RegData          in   jump-register target
//   ShouldBranch     out  control transfer required (combinational)
//   PredictionMiss   out  conditional outcome differs from prediction (comb.)
//   Flush            out  squash younger instructions / redirect (comb.)
//   BranchTargetAddr out  correct next fetch address (combinational)
//   BranchCount      out  resolved conditional branches, saturating (registered)
//   MissCount        out  mispredictions, saturating (registered)
// ---------------------------------------------------------------------------
module branch_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             BranchTaken,
    input  logic             Branch,
    input  logic             BEQ_BNE,
    input  logic             Zero,
    input  logic             JumpReg,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] RegData,
    output logic             ShouldBranch,
    output logic             PredictionMiss,
    output logic             Flush,
    output logic [WIDTH-1:0] BranchTargetAddr,
    output logic [WIDTH-1:0] BranchCount,
    output logic [WIDTH-1:0] MissCount
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             cond;
    logic             cond_taken;
    logic             cond_branch;
    logic [WIDTH-1:0] taken_addr;

    logic [WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [WIDTH-1:0] miss_cnt_q,   miss_cnt_d;

    // ------------------------------------------------------------------
    // Outcome resolution (purely combinational, same-cycle)
    // ------------------------------------------------------------------
    always_comb begin
        cond        = BEQ_BNE ? ~Zero : Zero;
        cond_taken  = Branch & cond;
        // A jump-register suppresses the conditional-branch interpretation.
        cond_branch = Branch & ~JumpReg;
        // The sum is truncated to WIDTH bits, so the addition wraps.
        taken_addr  = PC + Imm;

        ShouldBranch   = JumpReg | cond_taken;
        PredictionMiss = cond_branch & (cond ^ BranchTaken);
        // Jump-registers are never predicted, so they always redirect.
        Flush          = PredictionMiss | JumpReg;

        // The fall-through PC is needed to recover from a predicted-taken
        // branch that resolved not-taken.
        if (JumpReg) begin
            BranchTargetAddr = RegData;
        end else if (cond_taken) begin
            BranchTargetAddr = taken_addr;
        end else begin
            BranchTargetAddr = PC;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (cond_branch && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (PredictionMiss && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // Reset has priority over an increment on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        BranchTaken;
    logic        Branch;
    logic        BEQ_BNE;
    logic        Zero;
    logic        JumpReg;
    logic [15:0] PC;
    logic [15:0] Imm;
    logic [15:0] RegData;
    logic        ShouldBranch;
    logic        PredictionMiss;
    logic        Flush;
    logic [15:0] BranchTargetAddr;
    logic [15:0] BranchCount;
    logic [15:0] MissCount;

    int checks;
    int failures;

    branch_unit #(.WIDTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .BranchTaken      (BranchTaken),
        .Branch           (Branch),
        .BEQ_BNE          (BEQ_BNE),
        .Zero             (Zero),
        .JumpReg          (JumpReg),
        .PC               (PC),
        .Imm              (Imm),
        .RegData          (RegData),
        .ShouldBranch     (ShouldBranch),
        .PredictionMiss   (PredictionMiss),
        .Flush            (Flush),
        .BranchTargetAddr (BranchTargetAddr),
        .BranchCount      (BranchCount),
        .MissCount        (MissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the control inputs (stimulus only, no checking).
    task automatic set_in(input logic br, input logic bb, input logic z,
                          input logic bt, input logic jr);
        Branch      = br;
        BEQ_BNE     = bb;
        Zero        = z;
        BranchTaken = bt;
        JumpReg     = jr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h exp=0000/0000", BranchCount, MissCount);
        end
        $display("reset: BranchCount=%h MissCount=%h", BranchCount, MissCount);
    endtask

    task automatic test_idle();
        PC = 16'h0001; Imm = 16'h000F; RegData = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, i[0], i[1], i[0] ^ i[1], 1'b0);
            #1;
            checks++;
            if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b000, 16'h0001}) begin
                failures++;
                $display("FAIL idle_%0d got sb=%b pm=%b fl=%b tgt=%h exp sb=0 pm=0 fl=0 tgt=0001",
                         i, ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
            end
            $display("idle_%0d: sb=%b pm=%b fl=%b tgt=%h", i, ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
    endtask

    task automatic test_beq();
        PC = 16'h0001; Imm = 16'h000F; RegData = 16'hFFFF;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b111, 16'h0010}) begin
            failures++;
            $display("FAIL beq_miss got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=1 fl=1 tgt=0010",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("beq_miss: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        BranchTaken = 1'b1;
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b100, 16'h0010}) begin
            failures++;
            $display("FAIL beq_hit got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=0 fl=0 tgt=0010",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("beq_hit: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        // BEQ with Zero=0, correctly predicted not-taken
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b000, 16'h0001}) begin
            failures++;
            $display("FAIL beq_nt_hit got sb=%b pm=%b fl=%b tgt=%h exp sb=0 pm=0 fl=0 tgt=0001",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("beq_nt_hit: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
    endtask

    task automatic test_bne();
        PC = 16'h0001; Imm = 16'h000F; RegData = 16'hFFFF;
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b011, 16'h0001}) begin
            failures++;
            $display("FAIL bne_miss got sb=%b pm=%b fl=%b tgt=%h exp sb=0 pm=1 fl=1 tgt=0001",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("bne_miss: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        Zero = 1'b0;
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b100, 16'h0010}) begin
            failures++;
            $display("FAIL bne_hit got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=0 fl=0 tgt=0010",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("bne_hit: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
    endtask

    task automatic test_jump_and_wrap();
        PC = 16'h0001; Imm = 16'h000F; RegData = 16'hFFFF;
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b101, 16'hFFFF}) begin
            failures++;
            $display("FAIL jumpreg got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=0 fl=1 tgt=FFFF",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("jumpreg: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        PC = 16'hFFFF; Imm = 16'h0002;
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b100, 16'h0001}) begin
            failures++;
            $display("FAIL wrap got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=0 fl=0 tgt=0001",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("wrap: sb=%b pm=%b fl=%b tgt=%h", ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        // Negative offset: 0x0020 + (-4) = 0x001C
        PC = 16'h0020; Imm = 16'hFFFC;
        #1;
        checks++;
        if (BranchTargetAddr !== 16'h001C) begin
            failures++;
            $display("FAIL neg_offset got tgt=%h exp tgt=001C", BranchTargetAddr);
        end
        $display("neg_offset: tgt=%h", BranchTargetAddr);
        PC = 16'h0001; Imm = 16'h000F;
    endtask

    task automatic test_counters();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({BranchCount, MissCount} !== 32'h0000_0000) begin
            failures++;
            $display("FAIL cnt_reset got=%h/%h exp=0000/0000", BranchCount, MissCount);
        end
        // First mispredicted branch: one-cycle update latency
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== {16'd1, 16'd1}) begin
            failures++;
            $display("FAIL cnt_first got=%h/%h exp=0001/0001", BranchCount, MissCount);
        end
        $display("cnt_first: BranchCount=%h MissCount=%h", BranchCount, MissCount);
        @(negedge clk);
        @(negedge clk);
        // Two correctly predicted branches
        BranchTaken = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== {16'd5, 16'd3}) begin
            failures++;
            $display("FAIL cnt_five got=%h/%h exp=0005/0003", BranchCount, MissCount);
        end
        $display("cnt_five: BranchCount=%h MissCount=%h", BranchCount, MissCount);
        // Jump-register with Branch=1 and idle cycles must not count
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== {16'd5, 16'd3}) begin
            failures++;
            $display("FAIL cnt_nocount got=%h/%h exp=0005/0003", BranchCount, MissCount);
        end
        $display("cnt_nocount: BranchCount=%h MissCount=%h", BranchCount, MissCount);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (65535) @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sat_reach got=%h/%h exp=FFFF/FFFF", BranchCount, MissCount);
        end
        $display("sat_reach: BranchCount=%h MissCount=%h", BranchCount, MissCount);
        repeat (3) @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h/%h exp=FFFF/FFFF", BranchCount, MissCount);
        end
        $display("sat_hold: BranchCount=%h MissCount=%h", BranchCount, MissCount);
    endtask

    task automatic test_reset_priority();
        // Miss still present on the reset edge: reset wins.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== 32'h0000_0000) begin
            failures++;
            $display("FAIL rst_prio got=%h/%h exp=0000/0000", BranchCount, MissCount);
        end
        checks++;
        if ({ShouldBranch, PredictionMiss, Flush, BranchTargetAddr} !== {3'b111, 16'h0010}) begin
            failures++;
            $display("FAIL rst_comb got sb=%b pm=%b fl=%b tgt=%h exp sb=1 pm=1 fl=1 tgt=0010",
                     ShouldBranch, PredictionMiss, Flush, BranchTargetAddr);
        end
        $display("rst_prio: BranchCount=%h MissCount=%h pm=%b", BranchCount, MissCount, PredictionMiss);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({BranchCount, MissCount} !== {16'd1, 16'd1}) begin
            failures++;
            $display("FAIL rst_resume got=%h/%h exp=0001/0001", BranchCount, MissCount);
        end
        $display("rst_resume: BranchCount=%h MissCount=%h", BranchCount, MissCount);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        PC       = 16'h0001;
        Imm      = 16'h000F;
        RegData  = 16'hFFFF;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        rst_n = 1'b1;
        test_idle();
        test_beq();
        test_bne();
        test_jump_and_wrap();
        test_counters();
        test_saturation();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
